// File: rtl/pio_pkg.sv
// pio_loader shared package: pio action codes and loader FSM states.
// SIDES state exists only when PIO_LOADER_SIDES_EN is defined.
package pio_pkg;

    localparam int ACTION_W = 4;

    localparam logic [ACTION_W-1:0] NONE  = 4'd0;
    localparam logic [ACTION_W-1:0] INSTR = 4'd1;
    localparam logic [ACTION_W-1:0] PEND  = 4'd2;
    localparam logic [ACTION_W-1:0] PULL  = 4'd3;
    localparam logic [ACTION_W-1:0] PUSH  = 4'd4;
    localparam logic [ACTION_W-1:0] GRPS  = 4'd5;
    localparam logic [ACTION_W-1:0] EN    = 4'd6;
    localparam logic [ACTION_W-1:0] DIV   = 4'd7;
    localparam logic [ACTION_W-1:0] SIDES = 4'd8;
    localparam logic [ACTION_W-1:0] IMM   = 4'd9;
    localparam logic [ACTION_W-1:0] SHIFT = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_INSTR,
        S_PEND,
        S_DIV,
        S_GRPS,
        S_SHIFT,
`ifdef PIO_LOADER_SIDES_EN
        S_SIDES,
`endif
        S_EN,
        S_RUN,
        S_PULL_WAIT
    } state_t;

endpackage

// File: rtl/pio_loader_if.sv
// pio action/din command bus between the loader (master) and pio (slave).
// Carries per-machine FIFO status back to the loader.
interface pio_loader_if;
    import pio_pkg::*;

    logic [ACTION_W-1:0] action;
    logic [4:0]          index;
    logic [1:0]          mindex;
    logic [31:0]         din;
    logic [31:0]         dout;
    logic [3:0]          tx_full;
    logic [3:0]          rx_empty;

    modport master (
        output action, index, mindex, din,
        input  dout, tx_full, rx_empty
    );

    modport slave (
        input  action, index, mindex, din,
        output dout, tx_full, rx_empty
    );

endinterface

// File: rtl/pio_stream_arb.sv
// RUN-phase arbiter: picks PULL over PUSH in NONE gap cycles and
// captures the pulled word one cycle after the PULL action.
module pio_stream_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        pull_wait,
    input  logic        gap,
    input  logic        rx_empty,
    input  logic        tx_full,
    input  logic        tx_valid,
    input  logic [31:0] dout,
    output logic        do_pull,
    output logic        do_push,
    output logic        cap,
    output logic        rx_valid,
    output logic [31:0] rx_data
);

    assign do_pull = run && gap && !rx_empty;
    assign do_push = run && gap && rx_empty && tx_valid && !tx_full;
    // PULL is on the bus in the first wait cycle; dout follows in the gap
    assign cap     = pull_wait && gap;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= cap;
            if (cap) rx_data <= dout;
        end
    end

endmodule

// File: rtl/pio_loader.sv
// Hardware initiator that loads a pio program/config, then bridges streams.
// Optional SIDES action stage: define PIO_LOADER_SIDES_EN.
module pio_loader
    import pio_pkg::*;
#(
    parameter int PLEN_W = 6,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        sm_sel,
    input  logic [PLEN_W-1:0] plen,
    input  logic [31:0]       cfg_pend,
    input  logic [23:0]       cfg_div,
    input  logic [31:0]       cfg_grps,
    input  logic [31:0]       cfg_shift,
`ifdef PIO_LOADER_SIDES_EN
    input  logic [31:0]       cfg_sides,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    pio_loader_if.master      pio,
    input  logic              tx_valid,
    input  logic [31:0]       tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [31:0]       rx_data,
    output logic              busy,
    output logic              running
);

    state_t state, state_n;
    logic   ph, ph_n;
    logic   latch;

    logic [ACTION_W-1:0] act_q, act_n;
    logic [ADDR_W-1:0]   idx_q, idx_n;
    logic [1:0]          mix_q, mix_n;
    logic [31:0]         din_q, din_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                busy_q, busy_n;
    logic                run_q, run_n;
    logic                rdy_q, rdy_n;

    logic [1:0]        sm_q;
    logic [PLEN_W-1:0] plen_q;
    logic [31:0]       pend_q;
    logic [23:0]       div_q;
    logic [31:0]       grps_q;
    logic [31:0]       shift_q;
`ifdef PIO_LOADER_SIDES_EN
    logic [31:0]       sides_q;
`endif

    logic [PLEN_W-1:0]   last_w;
    logic [ACTION_W-1:0] step_act;
    logic [31:0]         step_din;
    state_t              step_next;
    logic                do_pull, do_push, cap;

    assign last_w = plen_q - PLEN_W'(1);

    pio_stream_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .run       (state == S_RUN),
        .pull_wait (state == S_PULL_WAIT),
        .gap       (act_q == NONE),
        .rx_empty  (pio.rx_empty[sm_q]),
        .tx_full   (pio.tx_full[sm_q]),
        .tx_valid  (tx_valid),
        .dout      (pio.dout),
        .do_pull   (do_pull),
        .do_push   (do_push),
        .cap       (cap),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data)
    );

    // Configuration action table: what each config state issues and where it goes
    always_comb begin
        step_act  = NONE;
        step_din  = '0;
        step_next = S_IDLE;
        case (state)
            S_PEND: begin
                step_act  = PEND;
                step_din  = pend_q;
                step_next = S_DIV;
            end
            S_DIV: begin
                step_act  = DIV;
                step_din  = {8'b0, div_q};
                step_next = S_GRPS;
            end
            S_GRPS: begin
                step_act  = GRPS;
                step_din  = grps_q;
                step_next = S_SHIFT;
            end
            S_SHIFT: begin
                step_act  = SHIFT;
                step_din  = shift_q;
`ifdef PIO_LOADER_SIDES_EN
                step_next = S_SIDES;
`else
                step_next = S_EN;
`endif
            end
`ifdef PIO_LOADER_SIDES_EN
            S_SIDES: begin
                step_act  = SIDES;
                step_din  = sides_q;
                step_next = S_EN;
            end
`endif
            S_EN: begin
                step_act  = EN;
                step_din  = 32'd1;
                step_next = S_RUN;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        ph_n    = ph;
        latch   = 1'b0;
        act_n   = NONE;
        idx_n   = idx_q;
        mix_n   = mix_q;
        din_n   = din_q;
        addr_n  = addr_q;
        busy_n  = busy_q;
        run_n   = run_q;
        rdy_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    busy_n  = 1'b1;
                    ph_n    = 1'b0;
                    addr_n  = '0;
                    mix_n   = sm_sel;
                    state_n = (plen == '0) ? S_PEND : S_FETCH;
                end
            end
            S_FETCH: state_n = S_INSTR;
            S_INSTR: begin
                act_n = INSTR;
                idx_n = addr_q;
                din_n = {16'b0, rom_data};
                if (addr_q == last_w[ADDR_W-1:0]) begin
                    state_n = S_PEND;
                end else begin
                    addr_n  = addr_q + ADDR_W'(1);
                    state_n = S_FETCH;
                end
            end
            // First phase of each config state is the NONE gap
            S_PEND, S_DIV, S_GRPS, S_SHIFT,
`ifdef PIO_LOADER_SIDES_EN
            S_SIDES,
`endif
            S_EN: begin
                if (!ph) begin
                    ph_n = 1'b1;
                end else begin
                    ph_n    = 1'b0;
                    act_n   = step_act;
                    din_n   = step_din;
                    state_n = step_next;
                    if (state == S_EN) begin
                        busy_n = 1'b0;
                        run_n  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (do_pull) begin
                    act_n   = PULL;
                    state_n = S_PULL_WAIT;
                end else if (do_push) begin
                    act_n = PUSH;
                    din_n = tx_data;
                    rdy_n = 1'b1;
                end
            end
            S_PULL_WAIT: begin
                if (cap) state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ph     <= 1'b0;
            act_q  <= NONE;
            idx_q  <= '0;
            mix_q  <= '0;
            din_q  <= '0;
            addr_q <= '0;
            busy_q <= 1'b0;
            run_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            state  <= state_n;
            ph     <= ph_n;
            act_q  <= act_n;
            idx_q  <= idx_n;
            mix_q  <= mix_n;
            din_q  <= din_n;
            addr_q <= addr_n;
            busy_q <= busy_n;
            run_q  <= run_n;
            rdy_q  <= rdy_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sm_q    <= '0;
            plen_q  <= '0;
            pend_q  <= '0;
            div_q   <= '0;
            grps_q  <= '0;
            shift_q <= '0;
`ifdef PIO_LOADER_SIDES_EN
            sides_q <= '0;
`endif
        end else if (latch) begin
            sm_q    <= sm_sel;
            plen_q  <= plen;
            pend_q  <= cfg_pend;
            div_q   <= cfg_div;
            grps_q  <= cfg_grps;
            shift_q <= cfg_shift;
`ifdef PIO_LOADER_SIDES_EN
            sides_q <= cfg_sides;
`endif
        end
    end

    assign pio.action = act_q;
    assign pio.index  = idx_q;
    assign pio.mindex = mix_q;
    assign pio.din    = din_q;
    assign rom_addr   = addr_q;
    assign tx_ready   = rdy_q;
    assign busy       = busy_q;
    assign running    = run_q;

endmodule

// File: tb/tb_pio_loader.sv
// Directed bench for pio_loader: program load, config actions, RUN streams.
// Expected values are hand-computed from the command sequence.
module tb_pio_loader;
    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sm_sel = 2'd0;
    logic [5:0]  plen = 6'd0;
    logic [31:0] cfg_pend = 32'h0000_1F00;
    logic [23:0] cfg_div = 24'h000100;
    logic [31:0] cfg_grps = 32'h0010_0000;
    logic [31:0] cfg_shift = 32'hA008_0000;
`ifdef PIO_LOADER_SIDES_EN
    logic [31:0] cfg_sides = 32'h0000_0003;
`endif
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] rom [32];
    logic        tx_valid = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic        tx_ready, rx_valid, busy, running;
    logic [31:0] rx_data;

    int nv = 0;
    int nerr = 0;

    pio_loader_if pio();

    pio_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sm_sel    (sm_sel),
        .plen      (plen),
        .cfg_pend  (cfg_pend),
        .cfg_div   (cfg_div),
        .cfg_grps  (cfg_grps),
        .cfg_shift (cfg_shift),
`ifdef PIO_LOADER_SIDES_EN
        .cfg_sides (cfg_sides),
`endif
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pio       (pio),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .busy      (busy),
        .running   (running)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nv++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic gap(input string tag);
        @(negedge clk);
        chk({tag, "_gap"}, 32'(pio.action), 32'(NONE));
    endtask

    task automatic wait_act(input string tag, input int lim);
        int n = 0;
        while (pio.action === NONE && n < lim) begin
            @(negedge clk);
            n++;
        end
        nv++;
        assert (pio.action !== NONE) else begin
            nerr++;
            $error("FAIL %s_timeout: observed %h expected non-NONE",
                   tag, pio.action);
        end
    endtask

    task automatic exp_act(input string tag, input logic [3:0] a,
                           input logic [31:0] d, input logic [1:0] m);
        wait_act(tag, 20);
        chk({tag, "_act"}, 32'(pio.action), 32'(a));
        chk({tag, "_din"}, pio.din, d);
        chk({tag, "_mix"}, 32'(pio.mindex), 32'(m));
    endtask

    task automatic cfg_seq(input logic [1:0] m);
        exp_act("pend", PEND, cfg_pend, m);
        gap("pend");
        exp_act("div", DIV, {8'b0, cfg_div}, m);
        gap("div");
        exp_act("grps", GRPS, cfg_grps, m);
        gap("grps");
        exp_act("shift", SHIFT, cfg_shift, m);
        gap("shift");
`ifdef PIO_LOADER_SIDES_EN
        exp_act("sides", SIDES, cfg_sides, m);
        gap("sides");
`endif
        exp_act("en", EN, 32'd1, m);
        chk("en_running", 32'(running), 32'd1);
        chk("en_busy", 32'(busy), 32'd0);
        gap("en");
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
        rom[0] = 16'h6001;
        rom[1] = 16'h0000;
        pio.dout     = 32'd0;
        pio.tx_full  = 4'h0;
        pio.rx_empty = 4'hF;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_action", 32'(pio.action), 32'(NONE));
        chk("rst_index", 32'(pio.index), 32'd0);
        chk("rst_mindex", 32'(pio.mindex), 32'd0);
        chk("rst_din", pio.din, 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_running", 32'(running), 32'd0);

        // plen=2 program load on machine 1; sm_sel changes after latch
        sm_sel = 2'd1;
        plen   = 6'd2;
        pulse_start();
        sm_sel = 2'd0;
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_running", 32'(running), 32'd0);
        exp_act("i0", INSTR, 32'h0000_6001, 2'd1);
        chk("i0_index", 32'(pio.index), 32'd0);
        gap("i0");
        exp_act("i1", INSTR, 32'h0000_0000, 2'd1);
        chk("i1_index", 32'(pio.index), 32'd1);
        gap("i1");
        cfg_seq(2'd1);
        gap("idle_run");

        // Ten pushes, data advanced on each tx_ready
        tx_valid = 1'b1;
        tx_data  = 32'd0;
        for (int i = 0; i < 10; i++) begin
            exp_act("push", PUSH, 32'(i), 2'd1);
            chk("push_rdy", 32'(tx_ready), 32'd1);
            tx_data = 32'(i + 1);
            if (i == 9) tx_valid = 1'b0;
            gap("push");
            chk("push_rdy_lo", 32'(tx_ready), 32'd0);
        end

        // Selected TX FIFO full blocks pushes
        pio.tx_full = 4'b0010;
        tx_valid    = 1'b1;
        tx_data     = 32'h55;
        for (int i = 0; i < 4; i++) begin
            gap("full");
            chk("full_rdy", 32'(tx_ready), 32'd0);
        end
        pio.tx_full = 4'b1101;
        exp_act("resume", PUSH, 32'h55, 2'd1);
        chk("resume_rdy", 32'(tx_ready), 32'd1);
        tx_valid = 1'b0;
        gap("resume");

        // Other machine's RX data must not trigger PULL
        pio.rx_empty = 4'b1110;
        for (int i = 0; i < 3; i++) gap("rx_other");

        // PULL beats a pending PUSH
        pio.rx_empty = 4'b1101;
        tx_valid     = 1'b1;
        tx_data      = 32'h77;
        exp_act("pull", PULL, pio.din, 2'd1);
        chk("pull_act", 32'(pio.action), 32'(PULL));
        chk("pull_rdy", 32'(tx_ready), 32'd0);
        pio.rx_empty = 4'hF;
        @(negedge clk);
        chk("pull_gap", 32'(pio.action), 32'(NONE));
        chk("pull_rxv0", 32'(rx_valid), 32'd0);
        pio.dout = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("pull_rxv", 32'(rx_valid), 32'd1);
        chk("pull_rxd", rx_data, 32'hDEAD_BEEF);
        pio.dout = 32'd0;
        exp_act("after_pull", PUSH, 32'h77, 2'd1);
        tx_valid = 1'b0;
        gap("after_pull");
        chk("rxv_lo", 32'(rx_valid), 32'd0);

        // start ignored in RUN
        pulse_start();
        for (int i = 0; i < 3; i++) gap("run_start");
        chk("run_start_busy", 32'(busy), 32'd0);
        chk("run_start_running", 32'(running), 32'd1);

        // plen=0 skips INSTR on machine 2
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        sm_sel = 2'd2;
        plen   = 6'd0;
        pulse_start();
        cfg_seq(2'd2);

        // Reset during INSTR index 1 abandons the sequence
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        sm_sel = 2'd1;
        plen   = 6'd2;
        pulse_start();
        exp_act("r_i0", INSTR, 32'h0000_6001, 2'd1);
        gap("r_i0");
        wait_act("r_i1", 20);
        chk("r_i1_index", 32'(pio.index), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("r_action", 32'(pio.action), 32'(NONE));
        chk("r_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) gap("r_quiet");

        // Full 32-word program restarts from index 0 without wrap
        plen = 6'd32;
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            exp_act("p32", INSTR, {16'b0, rom[i]}, 2'd1);
            chk("p32_index", 32'(pio.index), 32'(i));
            gap("p32");
        end
        cfg_seq(2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
